// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 Clause 22 MDIO initiator for PHY register reads and writes.
// The MDIO line is split into mdio_out / mdio_en / mdio_in. The tristate buffer
// belongs at the chip top level.
// Optional feature: define MDIO_PRE_SUPPRESS_EN so that only the first frame
// after reset carries the preamble.
module mdio_master #(
  parameter int unsigned CLK_DIV      = 10,
  parameter int unsigned PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_en,
  input  logic        mdio_in
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $fatal(1, "mdio_master: CLK_DIV must be >= 2");
  end

  localparam int unsigned PH_W    = $clog2(2 * CLK_DIV);
  localparam int unsigned CNT_MAX = (PREAMBLE_LEN > 16) ? PREAMBLE_LEN : 16;
  localparam int unsigned BIT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PH_W-1:0]  PH_RISE   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_LEN - 1);
  localparam logic [BIT_W-1:0] HDR_LAST  = BIT_W'(13);
  localparam logic [BIT_W-1:0] TA_LAST   = BIT_W'(1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(15);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [31:0]       sh_q, sh_d;
  logic [15:0]       rd_q, rd_d;
  logic              write_q, write_d;
  logic              ta_err_q, ta_err_d;
  logic              mdc_q, mdc_d;
  logic              out_q, out_d;
  logic              en_q, en_d;
  logic [15:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              skip_pre;
  logic [31:0]       frame_w;

  // ST, OP, PHYAD, REGAD, then TA + data for writes; reads park TA/data at 1
  // since the line is released for those bits anyway.
  assign frame_w = {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr, cmd_reg_addr,
                    (cmd_write ? {2'b10, cmd_wdata} : 18'h3FFFF)};

`ifdef MDIO_PRE_SUPPRESS_EN
  logic pre_sent_q, pre_sent_d;

  // Remember that a preamble has gone out since reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pre_sent_q <= 1'b0;
    end else begin
      pre_sent_q <= pre_sent_d;
    end
  end

  // Set on the first accepted command.
  always_comb begin
    pre_sent_d = pre_sent_q;
    if (state_q == S_IDLE && cmd_valid) begin
      pre_sent_d = 1'b1;
    end
  end

  assign skip_pre = pre_sent_q || (PREAMBLE_LEN == 0);
`else
  assign skip_pre = (PREAMBLE_LEN == 0);
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mdc       = mdc_q;
  assign mdio_out  = out_q;
  assign mdio_en   = en_q;

  // FSM state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and pin registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ph_q        <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      rd_q        <= '0;
      write_q     <= 1'b0;
      ta_err_q    <= 1'b0;
      mdc_q       <= 1'b0;
      out_q       <= 1'b1;
      en_q        <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ph_q        <= ph_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      rd_q        <= rd_d;
      write_q     <= write_d;
      ta_err_q    <= ta_err_d;
      mdc_q       <= mdc_d;
      out_q       <= out_d;
      en_q        <= en_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state, bit timing, pin values and read capture.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    rd_d        = rd_q;
    write_d     = write_q;
    ta_err_d    = ta_err_q;
    mdc_d       = mdc_q;
    out_d       = out_q;
    en_d        = en_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          write_d  = cmd_write;
          ph_d     = '0;
          bit_d    = '0;
          mdc_d    = 1'b0;
          en_d     = 1'b1;
          ta_err_d = 1'b0;
          rd_d     = '0;
          if (skip_pre) begin
            state_d = S_HDR;
            out_d   = frame_w[31];
            sh_d    = {frame_w[30:0], 1'b0};
          end else begin
            state_d = S_PRE;
            out_d   = 1'b1;
            sh_d    = frame_w;
          end
        end
      end

      S_PRE, S_HDR, S_TA, S_DATA: begin
        ph_d = ph_q + PH_W'(1);

        // MDC rising edge: the PHY's bit is sampled here.
        if (ph_q == PH_RISE) begin
          mdc_d = 1'b1;
          if (!write_q && state_q == S_TA && bit_q == TA_LAST) begin
            ta_err_d = mdio_in;
          end
          if (!write_q && state_q == S_DATA) begin
            rd_d = {rd_q[14:0], mdio_in};
          end
        end

        // End of bit: advance and present the next bit with MDC low.
        if (ph_q == PH_LAST) begin
          ph_d  = '0;
          mdc_d = 1'b0;
          bit_d = bit_q + BIT_W'(1);
          case (state_q)
            S_PRE:  if (bit_q == PRE_LAST)  begin state_d = S_HDR;  bit_d = '0; end
            S_HDR:  if (bit_q == HDR_LAST)  begin state_d = S_TA;   bit_d = '0; end
            S_TA:   if (bit_q == TA_LAST)   begin state_d = S_DATA; bit_d = '0; end
            S_DATA: if (bit_q == DATA_LAST) begin state_d = S_DONE; bit_d = '0; end
            default: ;
          endcase

          if (state_d == S_DONE) begin
            out_d       = 1'b1;
            en_d        = 1'b0;
            rsp_rdata_d = write_q ? 16'h0000 : rd_q;
            rsp_err_d   = write_q ? 1'b0 : ta_err_q;
          end else if (state_d == S_PRE) begin
            out_d = 1'b1;
            en_d  = 1'b1;
          end else begin
            out_d = sh_q[31];
            sh_d  = {sh_q[30:0], 1'b0};
            en_d  = write_q || (state_d == S_HDR);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed bench for mdio_master with a small PHY responder.
module tb_mdio_master;

  localparam int unsigned CLK_DIV = 10;
  localparam int unsigned PRE_LEN = 32;

  logic        clk;
  logic        arst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_en;
  logic        mdio_in;

  int n_checks;
  int n_fail;
  int cyc;

  int           bit_idx;
  logic         mdc_prev;
  logic [127:0] cap_out, cap_en, last_out, last_en;
  int           last_len;
  int           rv_count;

  logic        bfm_present;
  logic [15:0] bfm_data;
  int          cur_pre;
  logic        armed;

  mdio_master #(.CLK_DIV(CLK_DIV), .PREAMBLE_LEN(PRE_LEN)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_phy_addr (cmd_phy_addr),
    .cmd_reg_addr (cmd_reg_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mdc          (mdc),
    .mdio_out     (mdio_out),
    .mdio_en      (mdio_en),
    .mdio_in      (mdio_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // PHY answer for the bit starting now (index counted from frame start).
  function automatic logic bfm_bit(input int idx);
    if (!bfm_present) return 1'b1;
    if (idx == cur_pre + 15) return 1'b0;
    if (idx >= cur_pre + 16 && idx < cur_pre + 32) return bfm_data[15 - (idx - cur_pre - 16)];
    return 1'b1;
  endfunction

  // Frame monitor and PHY responder: records bits at MDC rise, drives mdio_in at MDC fall.
  initial begin : monitor
    bit_idx  = 0;
    mdc_prev = 1'b0;
    rv_count = 0;
    mdio_in  = 1'b1;
    cap_out  = '0;
    cap_en   = '0;
    last_out = '0;
    last_en  = '0;
    last_len = 0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        bit_idx  = 0;
        mdc_prev = 1'b0;
        mdio_in  = 1'b1;
        cap_out  = '0;
        cap_en   = '0;
      end else begin
        if (mdc && !mdc_prev) begin
          if (bit_idx < 128) begin
            cap_out[bit_idx] = mdio_out;
            cap_en[bit_idx]  = mdio_en;
          end
          bit_idx++;
        end
        if (!mdc && mdc_prev) mdio_in = bfm_bit(bit_idx);
        if (rsp_valid) begin
          last_out = cap_out;
          last_en  = cap_en;
          last_len = bit_idx;
          bit_idx  = 0;
          cap_out  = '0;
          cap_en   = '0;
          rv_count++;
          mdio_in  = 1'b1;
        end
        mdc_prev = mdc;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int exp_lat(input int pre);
    return (pre + 32) * 2 * int'(CLK_DIV) + 1;
  endfunction

  function automatic logic [15:0] field(input int start, input int len);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v = {v[14:0], last_out[start + i]};
    return v;
  endfunction

  task automatic pick_pre();
`ifdef MDIO_PRE_SUPPRESS_EN
    cur_pre = armed ? int'(PRE_LEN) : 0;
`else
    cur_pre = armed ? int'(PRE_LEN) : int'(PRE_LEN);
`endif
    armed = 1'b0;
  endtask

  // Issue one command, release cmd_valid after accept, wait for the response.
  task automatic do_cmd(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd, output int lat, output logic [15:0] rd,
                        output logic er, output logic ok);
    int n;
    int t_hs;
    ok  = 1'b0;
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    cmd_write    = w;
    cmd_phy_addr = pa;
    cmd_reg_addr = ra;
    cmd_wdata    = wd;
    cmd_valid    = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      step();
      n++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    pick_pre();
    t_hs = cyc;
    step();
    cmd_valid    = 1'b0;
    cmd_wdata    = ~wd;
    cmd_phy_addr = ~pa;
    cmd_reg_addr = ~ra;
    cmd_write    = ~w;
    n = 0;
    while (!rsp_valid && n < 5000) begin
      step();
      n++;
    end
    if (rsp_valid) begin
      ok  = 1'b1;
      lat = cyc - t_hs;
      rd  = rsp_rdata;
      er  = rsp_err;
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_phy_addr = '0;
    cmd_reg_addr = '0;
    cmd_wdata = '0;
    step();
    step();
    n_checks++; if (mdc !== 1'b0) begin n_fail++; $display("FAIL reset_mdc: got %b want 0", mdc); end
    n_checks++; if (mdio_en !== 1'b0) begin n_fail++; $display("FAIL reset_mdio_en: got %b want 0", mdio_en); end
    n_checks++; if (mdio_out !== 1'b1) begin n_fail++; $display("FAIL reset_mdio_out: got %b want 1", mdio_out); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0000", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    arst_n = 1'b1;
    armed = 1'b1;
    step();
  endtask

  task automatic test_write();
    int lat, p, ones, ens;
    logic [15:0] rd;
    logic er, ok;
    bfm_present = 1'b0;
    do_cmd(1'b1, 5'd1, 5'h04, 16'hA5C3, lat, rd, er, ok);
    p = cur_pre;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wr_timeout: got ok=%b want 1", ok); end
    n_checks++; if (lat != exp_lat(p)) begin n_fail++; $display("FAIL wr_latency: got %0d want %0d", lat, exp_lat(p)); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", er); end
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL wr_rdata: got %h want 0000", rd); end
    n_checks++; if (last_len != p + 32) begin n_fail++; $display("FAIL wr_bits: got %0d want %0d", last_len, p + 32); end
    ones = 0;
    for (int i = 0; i < p; i++) if (last_out[i]) ones++;
    n_checks++; if (ones != p) begin n_fail++; $display("FAIL wr_preamble: got %0d ones want %0d", ones, p); end
    n_checks++; if (field(p, 2) !== 16'h0001) begin n_fail++; $display("FAIL wr_st: got %h want 0001", field(p, 2)); end
    n_checks++; if (field(p + 2, 2) !== 16'h0001) begin n_fail++; $display("FAIL wr_op: got %h want 0001", field(p + 2, 2)); end
    n_checks++; if (field(p + 4, 5) !== 16'h0001) begin n_fail++; $display("FAIL wr_phyad: got %h want 0001", field(p + 4, 5)); end
    n_checks++; if (field(p + 9, 5) !== 16'h0004) begin n_fail++; $display("FAIL wr_regad: got %h want 0004", field(p + 9, 5)); end
    n_checks++; if (field(p + 14, 2) !== 16'h0002) begin n_fail++; $display("FAIL wr_ta: got %h want 0002", field(p + 14, 2)); end
    n_checks++; if (field(p + 16, 16) !== 16'hA5C3) begin n_fail++; $display("FAIL wr_data: got %h want a5c3", field(p + 16, 16)); end
    ens = 0;
    for (int i = 0; i < last_len && i < 128; i++) if (last_en[i]) ens++;
    n_checks++; if (ens != p + 32) begin n_fail++; $display("FAIL wr_en_bits: got %0d want %0d", ens, p + 32); end
    step();
    n_checks++; if (mdc !== 1'b0) begin n_fail++; $display("FAIL idle_mdc: got %b want 0", mdc); end
    n_checks++; if (mdio_en !== 1'b0) begin n_fail++; $display("FAIL idle_mdio_en: got %b want 0", mdio_en); end
    n_checks++; if (mdio_out !== 1'b1) begin n_fail++; $display("FAIL idle_mdio_out: got %b want 1", mdio_out); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_read();
    int lat, p, first_low, low_cnt;
    logic [15:0] rd;
    logic er, ok;
    bfm_present = 1'b1;
    bfm_data = 16'h0141;
    do_cmd(1'b0, 5'd1, 5'h02, 16'h0000, lat, rd, er, ok);
    p = cur_pre;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rd_timeout: got ok=%b want 1", ok); end
    n_checks++; if (lat != exp_lat(p)) begin n_fail++; $display("FAIL rd_latency: got %0d want %0d", lat, exp_lat(p)); end
    n_checks++; if (rd !== 16'h0141) begin n_fail++; $display("FAIL rd_rdata: got %h want 0141", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", er); end
    n_checks++; if (field(p + 2, 2) !== 16'h0002) begin n_fail++; $display("FAIL rd_op: got %h want 0002", field(p + 2, 2)); end
    n_checks++; if (field(p + 4, 5) !== 16'h0001) begin n_fail++; $display("FAIL rd_phyad: got %h want 0001", field(p + 4, 5)); end
    n_checks++; if (field(p + 9, 5) !== 16'h0002) begin n_fail++; $display("FAIL rd_regad: got %h want 0002", field(p + 9, 5)); end
    first_low = -1;
    low_cnt = 0;
    for (int i = 0; i < last_len && i < 128; i++) begin
      if (!last_en[i]) begin
        low_cnt++;
        if (first_low < 0) first_low = i;
      end
    end
    n_checks++; if (first_low != p + 14) begin n_fail++; $display("FAIL rd_en_fall: got bit %0d want %0d", first_low, p + 14); end
    n_checks++; if (low_cnt != 18) begin n_fail++; $display("FAIL rd_en_low_bits: got %0d want 18", low_cnt); end
  endtask

  task automatic test_absent_phy();
    int lat;
    logic [15:0] rd;
    logic er, ok;
    bfm_present = 1'b0;
    do_cmd(1'b0, 5'd7, 5'h02, 16'h0000, lat, rd, er, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL abs_timeout: got ok=%b want 1", ok); end
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL abs_err: got %b want 1", er); end
    n_checks++; if (rd !== 16'hFFFF) begin n_fail++; $display("FAIL abs_rdata: got %h want ffff", rd); end
    n_checks++; if (field(cur_pre + 4, 5) !== 16'h0007) begin n_fail++; $display("FAIL abs_phyad: got %h want 0007", field(cur_pre + 4, 5)); end
    repeat (3) step();
    n_checks++; if (rsp_rdata !== 16'hFFFF) begin n_fail++; $display("FAIL abs_rdata_hold: got %h want ffff", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL abs_err_hold: got %b want 1", rsp_err); end
  endtask

  task automatic test_back_to_back();
    int n, h1, r1, h2, p1, p2;
    bfm_present = 1'b1;
    bfm_data = 16'h3C5A;
    cmd_write = 1'b1;
    cmd_phy_addr = 5'd3;
    cmd_reg_addr = 5'd9;
    cmd_wdata = 16'h1234;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin step(); n++; end
    pick_pre();
    p1 = cur_pre;
    h1 = cyc;
    step();
    cmd_write = 1'b0;
    cmd_reg_addr = 5'd5;
    cmd_wdata = 16'hFFFF;
    n = 0;
    while (!rsp_valid && n < 5000) begin step(); n++; end
    r1 = cyc;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp1_timeout: got %b want 1", rsp_valid); end
    n_checks++; if (r1 - h1 != exp_lat(p1)) begin n_fail++; $display("FAIL b2b_latency1: got %0d want %0d", r1 - h1, exp_lat(p1)); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_done: got %b want 0", cmd_ready); end
    n_checks++; if (mdc !== 1'b0) begin n_fail++; $display("FAIL b2b_mdc_done: got %b want 0", mdc); end
    n_checks++; if (field(p1 + 9, 5) !== 16'h0009) begin n_fail++; $display("FAIL b2b_wr_regad: got %h want 0009", field(p1 + 9, 5)); end
    n_checks++; if (field(p1 + 16, 16) !== 16'h1234) begin n_fail++; $display("FAIL b2b_wr_data: got %h want 1234", field(p1 + 16, 16)); end
    step();
    h2 = cyc;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: got ready=%b want 1", cmd_ready); end
    n_checks++; if (h2 - r1 != 1) begin n_fail++; $display("FAIL b2b_gap: got %0d want 1", h2 - r1); end
    n_checks++; if (mdc !== 1'b0) begin n_fail++; $display("FAIL b2b_mdc_idle: got %b want 0", mdc); end
    pick_pre();
    p2 = cur_pre;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 5000) begin step(); n++; end
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp2_timeout: got %b want 1", rsp_valid); end
    n_checks++; if (cyc - h2 != exp_lat(p2)) begin n_fail++; $display("FAIL b2b_latency2: got %0d want %0d", cyc - h2, exp_lat(p2)); end
    n_checks++; if (rsp_rdata !== 16'h3C5A) begin n_fail++; $display("FAIL b2b_rd_rdata: got %h want 3c5a", rsp_rdata); end
    n_checks++; if (field(p2 + 9, 5) !== 16'h0005) begin n_fail++; $display("FAIL b2b_rd_regad: got %h want 0005", field(p2 + 9, 5)); end
    n_checks++; if (last_len != p2 + 32) begin n_fail++; $display("FAIL b2b_rd_bits: got %0d want %0d", last_len, p2 + 32); end
  endtask

  task automatic test_reset_midframe();
    int n, rv0, lat;
    logic [15:0] rd;
    logic er, ok;
    bfm_present = 1'b1;
    bfm_data = 16'hBEEF;
    cmd_write = 1'b0;
    cmd_phy_addr = 5'd1;
    cmd_reg_addr = 5'd3;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin step(); n++; end
    pick_pre();
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!(bit_idx >= 21 && mdc === 1'b1) && n < 3000) begin step(); n++; end
    n_checks++; if (bit_idx < 21) begin n_fail++; $display("FAIL mid_reach_bit20: got bit %0d want >= 21", bit_idx); end
    rv0 = rv_count;
    arst_n = 1'b0;
    #1;
    n_checks++; if (mdc !== 1'b0) begin n_fail++; $display("FAIL mid_mdc: got %b want 0", mdc); end
    n_checks++; if (mdio_en !== 1'b0) begin n_fail++; $display("FAIL mid_mdio_en: got %b want 0", mdio_en); end
    n_checks++; if (mdio_out !== 1'b1) begin n_fail++; $display("FAIL mid_mdio_out: got %b want 1", mdio_out); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if (rsp_rdata !== 16'h0000) begin n_fail++; $display("FAIL mid_rsp_rdata: got %h want 0000", rsp_rdata); end
    step();
    step();
    arst_n = 1'b1;
    armed = 1'b1;
    repeat (1400) step();
    n_checks++; if (rv_count != rv0) begin n_fail++; $display("FAIL mid_no_rsp: got %0d responses want %0d", rv_count, rv0); end
    n_checks++; if (bit_idx != 0) begin n_fail++; $display("FAIL mid_no_mdc: got %0d mdc edges want 0", bit_idx); end
    do_cmd(1'b0, 5'd1, 5'h03, 16'h0000, lat, rd, er, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_rd_timeout: got ok=%b want 1", ok); end
    n_checks++; if (lat != exp_lat(cur_pre)) begin n_fail++; $display("FAIL mid_rd_latency: got %0d want %0d", lat, exp_lat(cur_pre)); end
    n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL mid_rd_rdata: got %h want beef", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL mid_rd_err: got %b want 0", er); end
  endtask

`ifdef MDIO_PRE_SUPPRESS_EN
  task automatic test_pre_suppress();
    int lat;
    logic [15:0] rd;
    logic er, ok;
    arst_n = 1'b0;
    step();
    arst_n = 1'b1;
    armed = 1'b1;
    step();
    bfm_present = 1'b1;
    bfm_data = 16'h5A01;
    do_cmd(1'b0, 5'd2, 5'h01, 16'h0000, lat, rd, er, ok);
    n_checks++; if (lat != 1281) begin n_fail++; $display("FAIL sup_first_latency: got %0d want 1281", lat); end
    n_checks++; if (rd !== 16'h5A01) begin n_fail++; $display("FAIL sup_first_rdata: got %h want 5a01", rd); end
    bfm_data = 16'h00C7;
    do_cmd(1'b0, 5'd2, 5'h01, 16'h0000, lat, rd, er, ok);
    n_checks++; if (lat != 641) begin n_fail++; $display("FAIL sup_second_latency: got %0d want 641", lat); end
    n_checks++; if (rd !== 16'h00C7) begin n_fail++; $display("FAIL sup_second_rdata: got %h want 00c7", rd); end
    n_checks++; if (last_len != 32) begin n_fail++; $display("FAIL sup_second_bits: got %0d want 32", last_len); end
    n_checks++; if (field(0, 2) !== 16'h0001) begin n_fail++; $display("FAIL sup_second_st: got %h want 0001", field(0, 2)); end
    arst_n = 1'b0;
    step();
    arst_n = 1'b1;
    armed = 1'b1;
    step();
    do_cmd(1'b0, 5'd2, 5'h01, 16'h0000, lat, rd, er, ok);
    n_checks++; if (lat != 1281) begin n_fail++; $display("FAIL sup_rearm_latency: got %0d want 1281", lat); end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail = 0;
    bfm_present = 1'b0;
    bfm_data = '0;
    cur_pre = int'(PRE_LEN);
    armed = 1'b1;
    arst_n = 1'b0;
    cmd_valid = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_absent_phy();
    test_back_to_back();
    test_reset_midframe();
`ifdef MDIO_PRE_SUPPRESS_EN
    test_pre_suppress();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
